// File: rtl/lsu_pkg.sv
// LSU shared types: op encoding, stage FSM states and the Writeback bundle.
// Decode uses the same package to produce lsu_op.
package lsu_pkg;

   localparam int XLEN         = 32;
   localparam int LSU_OP_WIDTH = 4;

   typedef enum logic [LSU_OP_WIDTH-1:0] {
      LSU_NONE  = 4'd0,
      LSU_LD_B  = 4'd1,
      LSU_LD_H  = 4'd2,
      LSU_LD_W  = 4'd3,
      LSU_LD_BU = 4'd4,
      LSU_LD_HU = 4'd5,
      LSU_ST_B  = 4'd6,
      LSU_ST_H  = 4'd7,
      LSU_ST_W  = 4'd8
   } lsu_op_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DRAIN
   } mem_state_t;

   typedef enum logic [1:0] {
      SZ_B,
      SZ_H,
      SZ_W
   } lsu_size_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] result;
      logic            rw_en;
      logic [4:0]      rw_addr;
      logic            ale;
   } mem_wb_t;

   function automatic logic is_load(lsu_op_t op);
      return op inside {LSU_LD_B, LSU_LD_H, LSU_LD_W,
                        LSU_LD_BU, LSU_LD_HU};
   endfunction

   function automatic logic is_store(lsu_op_t op);
      return op inside {LSU_ST_B, LSU_ST_H, LSU_ST_W};
   endfunction

   function automatic lsu_size_t size_of(lsu_op_t op);
      lsu_size_t sz;
      unique case (op)
         LSU_LD_B, LSU_LD_BU, LSU_ST_B: sz = SZ_B;
         LSU_LD_H, LSU_LD_HU, LSU_ST_H: sz = SZ_H;
         default:                       sz = SZ_W;
      endcase
      return sz;
   endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Byte-lane steering: store strobes/replication, misalign check,
// and load lane extraction with sign or zero extension.
module mem_stage_align
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [LSU_OP_WIDTH-1:0] acc_op,
   input  logic [1:0]              acc_off,
   input  logic [DATA_WIDTH-1:0]   acc_data,
   output logic [3:0]              wstrb,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic                    misalign,
   input  logic [LSU_OP_WIDTH-1:0] ld_op,
   input  logic [1:0]              ld_off,
   input  logic [DATA_WIDTH-1:0]   rdata,
   output logic [DATA_WIDTH-1:0]   ld_data
);

   lsu_op_t               aop;
   lsu_op_t               lop;
   lsu_size_t             asz;
   logic [DATA_WIDTH-1:0] lane;

   assign aop  = lsu_op_t'(acc_op);
   assign lop  = lsu_op_t'(ld_op);
   assign asz  = size_of(aop);
   assign lane = rdata >> {ld_off, 3'b000};

   always_comb begin
      misalign = 1'b0;
      if (is_load(aop) || is_store(aop)) begin
         unique case (asz)
            SZ_H:    misalign = acc_off[0];
            SZ_W:    misalign = |acc_off;
            default: misalign = 1'b0;
         endcase
      end
   end

   always_comb begin
      wstrb = 4'h0;
      wdata = acc_data;
      if (is_store(aop)) begin
         unique case (asz)
            SZ_B: begin
               wstrb = 4'b0001 << acc_off;
               wdata = {4{acc_data[7:0]}};
            end
            SZ_H: begin
               wstrb = 4'b0011 << acc_off;
               wdata = {2{acc_data[15:0]}};
            end
            default: begin
               wstrb = 4'hF;
               wdata = acc_data;
            end
         endcase
      end
   end

   always_comb begin
      ld_data = rdata;
      unique case (1'b1)
         lop == LSU_LD_B:
            ld_data = {{24{lane[7]}}, lane[7:0]};
         lop == LSU_LD_BU:
            ld_data = {24'h0, lane[7:0]};
         lop == LSU_LD_H:
            ld_data = {{16{lane[15]}}, lane[15:0]};
         lop == LSU_LD_HU:
            ld_data = {16'h0, lane[15:0]};
         default:
            ld_data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: one in-order data access slot between
// Execute and Writeback, with registered result and flush/drain.
module mem_stage
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [31:0]             in_pc,
   input  logic [31:0]             in_inst,
   input  logic [DATA_WIDTH-1:0]   in_ex_result,
   input  logic [LSU_OP_WIDTH-1:0] in_lsu_op,
   input  logic [DATA_WIDTH-1:0]   in_lsu_data,
   input  logic                    in_rw_en,
   input  logic [4:0]              in_rw_addr,
   output logic                    dmem_req,
   output logic                    dmem_we,
   output logic [ADDR_WIDTH-1:0]   dmem_addr,
   output logic [3:0]              dmem_wstrb,
   output logic [DATA_WIDTH-1:0]   dmem_wdata,
   input  logic                    dmem_gnt,
   input  logic                    dmem_rvalid,
   input  logic [DATA_WIDTH-1:0]   dmem_rdata,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [31:0]             out_pc,
   output logic [31:0]             out_inst,
   output logic [DATA_WIDTH-1:0]   out_result,
   output logic                    out_rw_en,
   output logic [4:0]              out_rw_addr,
   output logic                    out_ale
);

   mem_state_t            state;
   mem_state_t            state_nxt;
   lsu_op_t               op_in;
   lsu_op_t               pend_op;
   logic [1:0]            pend_off;
   mem_wb_t               pend;
   mem_wb_t               wb_q;
   mem_wb_t               acc_wb;
   mem_wb_t               rsp_wb;
   logic [3:0]            a_wstrb;
   logic [DATA_WIDTH-1:0] a_wdata;
   logic                  a_mis;
   logic [DATA_WIDTH-1:0] ld_data;
   logic                  accept;
   logic                  mem_go;
   logic                  rsp_take;

   assign op_in = lsu_op_t'(in_lsu_op);

   mem_stage_align #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_align (
      .acc_op   (in_lsu_op),
      .acc_off  (in_ex_result[1:0]),
      .acc_data (in_lsu_data),
      .wstrb    (a_wstrb),
      .wdata    (a_wdata),
      .misalign (a_mis),
      .ld_op    (pend_op),
      .ld_off   (pend_off),
      .rdata    (dmem_rdata),
      .ld_data  (ld_data)
   );

   assign accept   = in_valid && in_ready;
   assign mem_go   = accept && !a_mis &&
                     (is_load(op_in) || is_store(op_in));
   assign rsp_take = (state == S_WAIT) && dmem_rvalid && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // A granted access cannot be recalled, so a late flush drains it.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      dmem_req  = 1'b0;
      unique case (state)
         S_IDLE: begin
            in_ready = (!out_valid || out_ready) && !flush;
            if (mem_go) state_nxt = S_REQ;
         end
         S_REQ: begin
            dmem_req = !flush;
            if (flush)         state_nxt = S_IDLE;
            else if (dmem_gnt) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (dmem_rvalid) state_nxt = S_IDLE;
            else if (flush)  state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (dmem_rvalid) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dmem_addr  <= '0;
         dmem_we    <= 1'b0;
         dmem_wstrb <= 4'h0;
         dmem_wdata <= '0;
         pend_op    <= LSU_NONE;
         pend_off   <= 2'b00;
         pend       <= '0;
      end else if (mem_go) begin
         dmem_addr  <= {in_ex_result[ADDR_WIDTH-1:2], 2'b00};
         dmem_we    <= is_store(op_in);
         dmem_wstrb <= a_wstrb;
         dmem_wdata <= a_wdata;
         pend_op    <= op_in;
         pend_off   <= in_ex_result[1:0];
         pend       <= '{pc:      in_pc,
                         inst:    in_inst,
                         result:  in_ex_result,
                         rw_en:   in_rw_en && is_load(op_in),
                         rw_addr: in_rw_addr,
                         ale:     1'b0};
      end
   end

   always_comb begin
      acc_wb = '{pc:      in_pc,
                 inst:    in_inst,
                 result:  in_ex_result,
                 rw_en:   in_rw_en && !a_mis,
                 rw_addr: in_rw_addr,
                 ale:     a_mis};
   end

   always_comb begin
      rsp_wb = pend;
      if (is_load(pend_op)) rsp_wb.result = ld_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         wb_q      <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (rsp_take) begin
         out_valid <= 1'b1;
         wb_q      <= rsp_wb;
      end else if (accept && !mem_go) begin
         out_valid <= 1'b1;
         wb_q      <= acc_wb;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign out_pc      = wb_q.pc;
   assign out_inst    = wb_q.inst;
   assign out_result  = wb_q.result;
   assign out_rw_en   = wb_q.rw_en;
   assign out_rw_addr = wb_q.rw_addr;
   assign out_ale     = wb_q.ale;

   rvalid_legal: assert property (
      @(posedge clk) disable iff (rst)
      dmem_rvalid |-> (state == S_WAIT || state == S_DRAIN));

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a
// randomized load/store stream against a byte-array memory model.
module tb_mem_stage;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_inst;
   logic [31:0] in_ex_result;
   logic [3:0]  in_lsu_op;
   logic [31:0] in_lsu_data;
   logic        in_rw_en;
   logic [4:0]  in_rw_addr;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_wstrb;
   logic [31:0] dmem_wdata;
   logic        dmem_gnt;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic [31:0] out_result;
   logic        out_rw_en;
   logic [4:0]  out_rw_addr;
   logic        out_ale;

   int checks = 0;
   int errors = 0;

   bit          mem_auto = 1'b0;
   logic        m_gnt = 1'b0, m_rv = 1'b0;
   logic [31:0] m_rdata = '0;
   logic        a_gnt = 1'b0, a_rv = 1'b0;
   logic [31:0] a_rdata = '0;
   logic [31:0] mem_w [0:255];
   logic [7:0]  ref_b [0:1023];

   assign dmem_gnt    = mem_auto ? a_gnt   : m_gnt;
   assign dmem_rvalid = mem_auto ? a_rv    : m_rv;
   assign dmem_rdata  = mem_auto ? a_rdata : m_rdata;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_inst(in_inst),
      .in_ex_result(in_ex_result), .in_lsu_op(in_lsu_op),
      .in_lsu_data(in_lsu_data), .in_rw_en(in_rw_en),
      .in_rw_addr(in_rw_addr),
      .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb),
      .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
      .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_inst(out_inst),
      .out_result(out_result), .out_rw_en(out_rw_en),
      .out_rw_addr(out_rw_addr), .out_ale(out_ale)
   );

   // Random-latency memory: grant after 0-3 cycles, respond 1-3 later.
   initial begin : responder
      int          gcnt;
      int          rcnt;
      bit          pend;
      logic [31:0] word;
      logic [7:0]  idx;
      gcnt = 0; rcnt = 0; pend = 0; word = '0;
      forever begin
         @(posedge clk); #1;
         a_gnt = 1'b0;
         a_rv  = 1'b0;
         if (mem_auto) begin
            if (pend) begin
               if (rcnt == 0) begin
                  a_rv = 1'b1; a_rdata = word; pend = 0;
               end else rcnt--;
            end else if (dmem_req) begin
               if (gcnt == 0) begin
                  a_gnt = 1'b1;
                  idx = dmem_addr[9:2];
                  if (dmem_we)
                     for (int k = 0; k < 4; k++)
                        if (dmem_wstrb[k])
                           mem_w[idx][8*k +: 8] = dmem_wdata[8*k +: 8];
                  word = mem_w[idx];
                  pend = 1;
                  rcnt = $urandom_range(0, 2);
                  gcnt = $urandom_range(0, 3);
               end else gcnt--;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not end, errors %0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic drive(lsu_op_t op, logic [31:0] ex,
                        logic [31:0] d, logic [4:0] rd);
      in_valid     = 1'b1;
      in_lsu_op    = op;
      in_ex_result = ex;
      in_lsu_data  = d;
      in_rw_en     = 1'b1;
      in_rw_addr   = rd;
      in_pc        = 32'h8000_0000 + ex;
      in_inst      = ~ex;
   endtask

   function automatic int size_bytes(lsu_op_t op);
      case (op)
         LSU_LD_H, LSU_LD_HU, LSU_ST_H: return 2;
         LSU_LD_W, LSU_ST_W:            return 4;
         default:                       return 1;
      endcase
   endfunction

   function automatic logic [31:0] ref_load(lsu_op_t op, int a);
      int v;
      case (op)
         LSU_LD_B:  begin v = ref_b[a]; if (v >= 128) v -= 256; end
         LSU_LD_BU: v = ref_b[a];
         LSU_LD_H:  begin
            v = ref_b[a] + 256 * ref_b[a+1];
            if (v >= 32768) v -= 65536;
         end
         LSU_LD_HU: v = ref_b[a] + 256 * ref_b[a+1];
         default:   v = {ref_b[a+3], ref_b[a+2], ref_b[a+1], ref_b[a]};
      endcase
      return v;
   endfunction

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_lsu_op = LSU_NONE; in_ex_result = '0; in_lsu_data = '0;
      in_rw_en = 1'b0; in_rw_addr = '0; in_pc = '0; in_inst = '0;
      repeat (3) tick();
      checks++; if (out_valid !== 1'b0) begin errors++;
         $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      checks++; if (dmem_req !== 1'b0) begin errors++;
         $display("FAIL rst_dmem_req: got %b want 0", dmem_req); end
      checks++; if (out_ale !== 1'b0 || out_result !== 32'h0) begin errors++;
         $display("FAIL rst_out_regs: ale %b result %h want 0/0", out_ale, out_result); end
      rst = 1'b0;
      tick();
      checks++; if (in_ready !== 1'b1) begin errors++;
         $display("FAIL rst_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_nonmem();
      drive(LSU_NONE, 32'h1234, 32'h0, 5'd5);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++;
         $display("FAIL nm_in_ready: got %b want 1", in_ready); end
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_result !== 32'h1234) begin errors++;
         $display("FAIL nm_result: valid %b result %h want 1/00001234", out_valid, out_result); end
      checks++; if (out_rw_en !== 1'b1 || out_rw_addr !== 5'd5 || out_ale !== 1'b0) begin errors++;
         $display("FAIL nm_rw: en %b addr %0d ale %b want 1/5/0", out_rw_en, out_rw_addr, out_ale); end
      checks++; if (out_pc !== 32'h8000_1234) begin errors++;
         $display("FAIL nm_pc: got %h want 80001234", out_pc); end
      checks++; if (dmem_req !== 1'b0) begin errors++;
         $display("FAIL nm_no_req: got %b want 0", dmem_req); end
      tick();
      checks++; if (out_valid !== 1'b0 || dmem_req !== 1'b0) begin errors++;
         $display("FAIL nm_drain: valid %b req %b want 0/0", out_valid, dmem_req); end
   endtask

   task automatic test_ld_b();
      drive(LSU_LD_B, 32'h1003, 32'h0, 5'd7);
      tick();
      in_valid = 1'b0;
      checks++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h1000 || dmem_we !== 1'b0) begin errors++;
         $display("FAIL ldb_req: req %b addr %h we %b want 1/00001000/0", dmem_req, dmem_addr, dmem_we); end
      checks++; if (in_ready !== 1'b0) begin errors++;
         $display("FAIL ldb_busy: in_ready %b want 0", in_ready); end
      m_gnt = 1'b1;
      tick();
      m_gnt = 1'b0; m_rv = 1'b1; m_rdata = 32'h80FF_0000;
      checks++; if (dmem_req !== 1'b0 || out_valid !== 1'b0) begin errors++;
         $display("FAIL ldb_wait: req %b valid %b want 0/0", dmem_req, out_valid); end
      tick();
      m_rv = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_result !== 32'hFFFF_FF80) begin errors++;
         $display("FAIL ldb_result: valid %b result %h want 1/ffffff80", out_valid, out_result); end
      checks++; if (out_rw_en !== 1'b1 || out_rw_addr !== 5'd7) begin errors++;
         $display("FAIL ldb_rw: en %b addr %0d want 1/7", out_rw_en, out_rw_addr); end
      tick();
   endtask

   task automatic test_st_h();
      drive(LSU_ST_H, 32'h2002, 32'h1234_ABCD, 5'd3);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (dmem_req !== 1'b1 || dmem_addr !== 32'h2000 || dmem_we !== 1'b1 ||
             dmem_wstrb !== 4'b1100 || dmem_wdata !== 32'hABCD_ABCD || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL sth_hold[%0d]: req %b addr %h we %b strb %b wdata %h rdy %b want 1/00002000/1/1100/abcdabcd/0",
                     i, dmem_req, dmem_addr, dmem_we, dmem_wstrb, dmem_wdata, in_ready);
         end
         if (i == 3) m_gnt = 1'b1;
         tick();
      end
      m_gnt = 1'b0; m_rv = 1'b1;
      tick();
      m_rv = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_rw_en !== 1'b0 || out_ale !== 1'b0) begin errors++;
         $display("FAIL sth_done: valid %b rw_en %b ale %b want 1/0/0", out_valid, out_rw_en, out_ale); end
      tick();
   endtask

   task automatic test_misalign();
      drive(LSU_LD_W, 32'h3001, 32'h0, 5'd9);
      tick();
      in_valid = 1'b0;
      checks++; if (dmem_req !== 1'b0) begin errors++;
         $display("FAIL mis_ldw_req: got %b want 0", dmem_req); end
      checks++; if (out_valid !== 1'b1 || out_ale !== 1'b1 || out_rw_en !== 1'b0) begin errors++;
         $display("FAIL mis_ldw_out: valid %b ale %b rw_en %b want 1/1/0", out_valid, out_ale, out_rw_en); end
      drive(LSU_ST_H, 32'h3003, 32'h55, 5'd0);
      tick();
      in_valid = 1'b0;
      checks++; if (dmem_req !== 1'b0 || out_valid !== 1'b1 || out_ale !== 1'b1) begin errors++;
         $display("FAIL mis_sth: req %b valid %b ale %b want 0/1/1", dmem_req, out_valid, out_ale); end
      tick();
   endtask

   task automatic test_flush();
      drive(LSU_LD_W, 32'h5000, 32'h0, 5'd4);
      tick();
      in_valid = 1'b0; m_gnt = 1'b1;
      tick();
      m_gnt = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if (in_ready !== 1'b0 || dmem_req !== 1'b0 || out_valid !== 1'b0) begin errors++;
         $display("FAIL fl_drain: rdy %b req %b valid %b want 0/0/0", in_ready, dmem_req, out_valid); end
      tick();
      m_rv = 1'b1; m_rdata = 32'hDEAD_BEEF;
      tick();
      m_rv = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
         $display("FAIL fl_dropped: valid %b rdy %b want 0/1", out_valid, in_ready); end
      drive(LSU_LD_HU, 32'h4002, 32'h0, 5'd6);
      tick();
      in_valid = 1'b0; m_gnt = 1'b1;
      tick();
      m_gnt = 1'b0; m_rv = 1'b1; m_rdata = 32'h8001_0000;
      tick();
      m_rv = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_result !== 32'h0000_8001) begin errors++;
         $display("FAIL fl_ldhu: valid %b result %h want 1/00008001", out_valid, out_result); end
      tick();
      drive(LSU_LD_W, 32'h6000, 32'h0, 5'd2);
      tick();
      in_valid = 1'b0;
      checks++; if (dmem_req !== 1'b1) begin errors++;
         $display("FAIL flreq_pre: req %b want 1", dmem_req); end
      flush = 1'b1;
      #1;
      checks++; if (dmem_req !== 1'b0) begin errors++;
         $display("FAIL flreq_drop: req %b want 0", dmem_req); end
      tick();
      flush = 1'b0;
      #1;
      checks++; if (dmem_req !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++;
         $display("FAIL flreq_idle: req %b rdy %b valid %b want 0/1/0", dmem_req, in_ready, out_valid); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive(LSU_NONE, 32'h5555_AAAA, 32'h0, 5'd9);
      tick();
      drive(LSU_LD_W, 32'h0100, 32'h0, 5'd10);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_result !== 32'h5555_AAAA || out_rw_addr !== 5'd9 ||
             in_ready !== 1'b0 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d]: valid %b result %h rd %0d rdy %b req %b want 1/5555aaaa/9/0/0",
                     i, out_valid, out_result, out_rw_addr, in_ready, dmem_req);
         end
         tick();
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++;
         $display("FAIL bp_release: rdy %b want 1", in_ready); end
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0 || dmem_req !== 1'b1 || dmem_addr !== 32'h100) begin errors++;
         $display("FAIL bp_next: valid %b req %b addr %h want 0/1/00000100", out_valid, dmem_req, dmem_addr); end
      m_gnt = 1'b1;
      tick();
      m_gnt = 1'b0; m_rv = 1'b1; m_rdata = 32'h1122_3344;
      tick();
      m_rv = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_result !== 32'h1122_3344) begin errors++;
         $display("FAIL bp_ldw: valid %b result %h want 1/11223344", out_valid, out_result); end
      tick();
   endtask

   task automatic test_reset_mid();
      drive(LSU_LD_W, 32'h0200, 32'h0, 5'd1);
      tick();
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      checks++; if (dmem_req !== 1'b0 || out_valid !== 1'b0) begin errors++;
         $display("FAIL rstmid: req %b valid %b want 0/0", dmem_req, out_valid); end
      tick();
      rst = 1'b0;
      tick();
      checks++; if (in_ready !== 1'b1 || dmem_req !== 1'b0) begin errors++;
         $display("FAIL rstmid_idle: rdy %b req %b want 1/0", in_ready, dmem_req); end
   endtask

   task automatic test_random();
      lsu_op_t     op;
      int          a;
      int          sz;
      int          t;
      bit          ld, st, mis;
      logic [31:0] d;
      logic [31:0] exp;
      logic [4:0]  rd;
      for (int i = 0; i < 256; i++) begin
         mem_w[i] = $urandom;
         for (int k = 0; k < 4; k++) ref_b[4*i+k] = mem_w[i][8*k +: 8];
      end
      mem_auto = 1'b1;
      for (int n = 0; n < 300; n++) begin
         op  = lsu_op_t'(4'($urandom_range(0, 8)));
         sz  = size_bytes(op);
         a   = $urandom_range(0, 1023);
         if ($urandom_range(0, 3) != 0) a = a - (a % sz);
         d   = $urandom;
         rd  = 5'($urandom_range(1, 31));
         ld  = op inside {LSU_LD_B, LSU_LD_H, LSU_LD_W, LSU_LD_BU, LSU_LD_HU};
         st  = op inside {LSU_ST_B, LSU_ST_H, LSU_ST_W};
         mis = (ld || st) && (a % sz != 0);
         t = 0;
         while (!in_ready && t < 50) begin tick(); t++; end
         checks++; if (!in_ready) begin errors++;
            $display("FAIL rnd_ready_timeout[%0d]: rdy %b want 1", n, in_ready); end
         drive(op, (ld || st) ? a : d, d, rd);
         tick();
         in_valid = 1'b0;
         t = 0;
         while (!out_valid && t < 50) begin tick(); t++; end
         exp = ld ? ref_load(op, a) : d;
         checks++;
         if (out_valid !== 1'b1 || out_ale !== mis ||
             out_rw_en !== (!mis && !st) || out_rw_addr !== rd ||
             (!st && !mis && out_result !== exp)) begin
            errors++;
            $display("FAIL rnd[%0d] op %0d addr %0d: valid %b ale %b rw_en %b rd %0d result %h want 1/%b/%b/%0d/%h",
                     n, op, a, out_valid, out_ale, out_rw_en, out_rw_addr, out_result,
                     mis, !mis && !st, rd, exp);
         end
         if (st && !mis)
            for (int k = 0; k < sz; k++) ref_b[a+k] = d[8*k +: 8];
         tick();
      end
      mem_auto = 1'b0;
   endtask

   initial begin
      test_reset();
      test_nonmem();
      test_ld_b();
      test_st_h();
      test_misalign();
      test_flush();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
